// File: rtl/control_path_param_if.sv
`default_nettype none
// ------------------------------------------------------------------
// control_path_param_if : mode request, status and datapath controls
// Rev 1.0
// ------------------------------------------------------------------
interface control_path_param_if #(
  parameter int STEP_W = 2
);
  logic [1:0]        on;
  logic              start;
  logic              flag;
  logic [1:0]        regime;
  logic              active;
  logic [1:0]        y_select_next;
  logic [STEP_W-1:0] s_step;
  logic              y_en;
  logic              s_en;
  logic              y_store_x;
  logic              s_add;
  logic              s_zero;
  logic              busy;
  logic              done;

  modport master (
    input  on, start, flag,
    output regime, active, y_select_next, s_step, y_en, s_en,
           y_store_x, s_add, s_zero, busy, done
  );

  modport slave (
    output on, start, flag,
    input  regime, active, y_select_next, s_step, y_en, s_en,
           y_store_x, s_add, s_zero, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/control_path_param.sv
`default_nettype none
// ------------------------------------------------------------------
// control_path_param : COUNT / ACCUM / SEQ controller for the s/y datapath
// Rev 1.0
// ------------------------------------------------------------------
module control_path_param #(
  parameter int STEP_W   = 2,
  parameter int CNT_N    = 5,
  parameter int CNT_GAP  = 3,
  parameter int CNT_STEP = 2,
  parameter int ACC_STEP = 1,
  parameter int ACC_MAX  = 15,
  parameter int SEQ_REP  = 1
) (
  input  wire logic            clk,
  input  wire logic            rst,
  control_path_param_if.master bus
);

  localparam int PCNT_W = $clog2(CNT_N + 1);
  localparam int GAP_W  = $clog2(CNT_GAP + 1);
  localparam int ACNT_W = (ACC_MAX > 0) ? $clog2(ACC_MAX + 1) : 1;
  localparam int REP_W  = $clog2(SEQ_REP + 1);

  localparam logic [PCNT_W-1:0] PCNT_LAST  = PCNT_W'(CNT_N - 1);
  localparam logic [GAP_W-1:0]  GAP_RELOAD = GAP_W'(CNT_GAP - 1);
  localparam logic [ACNT_W-1:0] ACNT_CAP   = ACNT_W'((ACC_MAX > 0) ? ACC_MAX : 1);
  localparam logic [ACNT_W-1:0] ACNT_LAST  = ACNT_W'((ACC_MAX > 0) ? ACC_MAX - 1 : 0);
  localparam logic [REP_W-1:0]  REP_LAST   = REP_W'(SEQ_REP - 1);
  localparam logic [STEP_W-1:0] STEP_CNT   = STEP_W'(CNT_STEP);
  localparam logic [STEP_W-1:0] STEP_ACC   = STEP_W'(ACC_STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_ACCUM = 2'd2,
    S_SEQ   = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [PCNT_W-1:0] pcnt, pcnt_n;
  logic [GAP_W-1:0]  gap, gap_n;
  logic [ACNT_W-1:0] acnt, acnt_n;
  logic [1:0]        phase, phase_n;
  logic [REP_W-1:0]  rep, rep_n;
  logic              done_r, done_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      pcnt   <= '0;
      gap    <= '0;
      acnt   <= '0;
      phase  <= '0;
      rep    <= '0;
      done_r <= 1'b0;
    end else begin
      state  <= state_n;
      pcnt   <= pcnt_n;
      gap    <= gap_n;
      acnt   <= acnt_n;
      phase  <= phase_n;
      rep    <= rep_n;
      done_r <= done_n;
    end
  end

  always_comb begin
    state_n           = state;
    pcnt_n            = pcnt;
    gap_n             = gap;
    acnt_n            = acnt;
    phase_n           = phase;
    rep_n             = rep;
    done_n            = 1'b0;
    bus.regime        = state;
    bus.busy          = (state != S_IDLE);
    bus.done          = done_r;
    bus.active        = 1'b0;
    bus.y_select_next = 2'd0;
    bus.s_step        = '0;
    bus.y_en          = 1'b0;
    bus.s_en          = 1'b0;
    bus.y_store_x     = 1'b0;
    bus.s_add         = 1'b0;
    bus.s_zero        = 1'b0;

    case (state)
      S_IDLE: begin
        pcnt_n  = '0;
        gap_n   = '0;
        acnt_n  = '0;
        phase_n = '0;
        rep_n   = '0;
        case (bus.on)
          2'b01:   state_n = S_COUNT;
          2'b10:   state_n = S_ACCUM;
          2'b11:   state_n = S_SEQ;
          default: state_n = S_IDLE;
        endcase
      end

      S_COUNT: begin
        if (bus.start) begin
          bus.active = 1'b1;
          if (gap == '0) begin
            bus.s_en   = 1'b1;
            bus.s_step = STEP_CNT;
            bus.s_zero = (pcnt == '0);
            if (pcnt == PCNT_LAST) begin
              state_n = S_IDLE;
              done_n  = 1'b1;
            end else begin
              pcnt_n = pcnt + PCNT_W'(1);
              gap_n  = GAP_RELOAD;
            end
          end else begin
            gap_n = gap - GAP_W'(1);
          end
        end else if (bus.on == 2'b00) begin
          // Paused with mode withdrawn: abandon the run silently.
          state_n = S_IDLE;
        end
      end

      S_ACCUM: begin
        if (bus.start) begin
          bus.active        = 1'b1;
          bus.s_en          = 1'b1;
          bus.s_add         = 1'b1;
          bus.s_step        = STEP_ACC;
          bus.y_en          = bus.flag;
          bus.y_select_next = {1'b0, bus.flag};
          if (acnt != ACNT_CAP) begin
            acnt_n = acnt + ACNT_W'(1);
          end
          if ((ACC_MAX != 0) && (acnt == ACNT_LAST)) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end
        end else begin
          state_n = S_IDLE;
        end
      end

      default: begin
        bus.active = 1'b1;
        case (phase)
          2'd0: begin
            bus.y_store_x = 1'b1;
            bus.y_en      = 1'b1;
            phase_n       = 2'd1;
          end
          2'd1: begin
            bus.y_select_next = 2'd2;
            bus.y_en          = 1'b1;
            phase_n           = 2'd2;
          end
          default: begin
            bus.s_en   = 1'b1;
            bus.s_step = STEP_W'(1);
            if (rep == REP_LAST) begin
              state_n = S_IDLE;
              done_n  = 1'b1;
            end else begin
              rep_n   = rep + REP_W'(1);
              phase_n = 2'd0;
            end
          end
        endcase
      end
    endcase
  end

endmodule
`default_nettype wire
